// File: rtl/axil_mux.sv
// N-to-1 AXI-Lite multiplexer: independent round-robin arbitration for the write and read paths,
// one outstanding transaction per path, responses routed only to the slot holding the grant.
module axil_mux #(
    parameter  int slot_num_p             = 2,
    localparam int axil_mosi_bus_width_lp = 32 + 1 + 32 + 4 + 1 + 1 + 32 + 1 + 1,
    localparam int axil_miso_bus_width_lp = 1 + 1 + 2 + 1 + 1 + 32 + 2 + 1
) (
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    input  logic [slot_num_p-1:0][axil_mosi_bus_width_lp-1:0]  s_axil_mux_i,
    output logic [slot_num_p-1:0][axil_miso_bus_width_lp-1:0]  s_axil_mux_o,
    output logic [axil_mosi_bus_width_lp-1:0]                  m_axil_bus_o,
    input  logic [axil_miso_bus_width_lp-1:0]                  m_axil_bus_i
);

    typedef struct packed {
        logic [31:0] awaddr;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic        arvalid;
        logic        rready;
    } mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } miso_t;

    localparam int sel_w_lp = $clog2(slot_num_p);
    typedef logic [sel_w_lp-1:0] sel_t;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_t;

    // First requester found when scanning upward from last+1, wrapping to 0.
    function automatic sel_t rr_pick(input logic [slot_num_p-1:0] req, input sel_t last);
        sel_t pick = last;
        for (int k = slot_num_p; k >= 1; k--) begin
            int idx;
            idx = (int'(last) + k) % slot_num_p;
            if (req[idx]) pick = sel_t'(idx);
        end
        return pick;
    endfunction

    mosi_t                 w_up [slot_num_p];
    logic [slot_num_p-1:0] w_awvalid_vec;
    logic [slot_num_p-1:0] w_arvalid_vec;
    miso_t                 w_dn;
    mosi_t                 w_dn_req;
    mosi_t                 w_wr_up;
    mosi_t                 w_rd_up;

    wr_state_t r_wr_state;
    rd_state_t r_rd_state;
    sel_t      r_wr_grant, r_wr_last, r_rd_grant, r_rd_last;
    logic      r_aw_done, r_w_done;
    logic      w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    for (genvar gi = 0; gi < slot_num_p; gi++) begin : g_unpack
        assign w_up[gi]          = mosi_t'(s_axil_mux_i[gi]);
        assign w_awvalid_vec[gi] = w_up[gi].awvalid;
        assign w_arvalid_vec[gi] = w_up[gi].arvalid;
    end

    assign w_dn    = miso_t'(m_axil_bus_i);
    assign w_wr_up = w_up[r_wr_grant];
    assign w_rd_up = w_up[r_rd_grant];

    always_comb begin
        w_dn_req = '0;
        if (r_wr_state == W_REQ) begin
            w_dn_req.awaddr  = w_wr_up.awaddr;
            w_dn_req.awvalid = w_wr_up.awvalid & ~r_aw_done;
            w_dn_req.wdata   = w_wr_up.wdata;
            w_dn_req.wstrb   = w_wr_up.wstrb;
            w_dn_req.wvalid  = w_wr_up.wvalid & ~r_w_done;
        end
        if (r_wr_state == W_RESP) w_dn_req.bready = w_wr_up.bready;
        if (r_rd_state == R_ADDR) begin
            w_dn_req.araddr  = w_rd_up.araddr;
            w_dn_req.arvalid = w_rd_up.arvalid;
        end
        if (r_rd_state == R_RESP) w_dn_req.rready = w_rd_up.rready;
    end

    assign m_axil_bus_o = w_dn_req;

    assign w_aw_hs = w_dn_req.awvalid & w_dn.awready;
    assign w_w_hs  = w_dn_req.wvalid  & w_dn.wready;
    assign w_b_hs  = w_dn_req.bready  & w_dn.bvalid;
    assign w_ar_hs = w_dn_req.arvalid & w_dn.arready;
    assign w_r_hs  = w_dn_req.rready  & w_dn.rvalid;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_state <= W_IDLE;
            r_wr_grant <= '0;
            r_wr_last  <= sel_t'(slot_num_p - 1);
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: if (|w_awvalid_vec) begin
                    r_wr_grant <= rr_pick(w_awvalid_vec, r_wr_last);
                    r_wr_state <= W_REQ;
                end
                // AW and W may finish in either order; leave once both have been accepted.
                W_REQ: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    r_wr_state <= W_RESP;
                    r_aw_done  <= 1'b0;
                    r_w_done   <= 1'b0;
                end else begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                W_RESP: if (w_b_hs) begin
                    r_wr_last  <= r_wr_grant;
                    r_wr_state <= W_IDLE;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_state <= R_IDLE;
            r_rd_grant <= '0;
            r_rd_last  <= sel_t'(slot_num_p - 1);
        end else begin
            case (r_rd_state)
                R_IDLE: if (|w_arvalid_vec) begin
                    r_rd_grant <= rr_pick(w_arvalid_vec, r_rd_last);
                    r_rd_state <= R_ADDR;
                end
                R_ADDR: if (w_ar_hs) r_rd_state <= R_RESP;
                R_RESP: if (w_r_hs) begin
                    r_rd_last  <= r_rd_grant;
                    r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < slot_num_p; gi++) begin : g_slot
        miso_t w_rsp;
        always_comb begin
            w_rsp = '0;
            if (r_wr_grant == sel_t'(gi)) begin
                w_rsp.awready = (r_wr_state == W_REQ) & ~r_aw_done & w_dn.awready;
                w_rsp.wready  = (r_wr_state == W_REQ) & ~r_w_done & w_dn.wready;
                if (r_wr_state == W_RESP) begin
                    w_rsp.bvalid = w_dn.bvalid;
                    w_rsp.bresp  = w_dn.bresp;
                end
            end
            if (r_rd_grant == sel_t'(gi)) begin
                w_rsp.arready = (r_rd_state == R_ADDR) & w_dn.arready;
                if (r_rd_state == R_RESP) begin
                    w_rsp.rvalid = w_dn.rvalid;
                    w_rsp.rdata  = w_dn.rdata;
                    w_rsp.rresp  = w_dn.rresp;
                end
            end
        end
        assign s_axil_mux_o[gi] = w_rsp;
    end

endmodule
